// File: rtl/run_sequencer_pkg.sv
// Shared types for the load/run/drain sequencer: FSM states and the
// 16-bit saturating run-cycle count.
package run_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DRAIN} state_t;

  typedef logic [15:0] cyc_t;

  localparam cyc_t CYC_SAT = 16'hFFFF;

endpackage

// File: rtl/run_sequencer_if.sv
// Host byte streams: operand bytes in, result bytes out, both valid/ready.
interface run_sequencer_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/run_timer.sv
// Saturating 16-bit cycle counter with synchronous clear and a flag that
// marks the cycle whose count-up reaches LIMIT.
module run_timer
  import run_sequencer_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output cyc_t cnt,
  output logic last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (en && (cnt != CYC_SAT))   cnt <= cnt + 16'd1;
  end

  // Looks one count ahead so the caller can leave on the LIMIT-th cycle.
  assign last = (cnt >= cyc_t'(LIMIT - 1));

endmodule

// File: rtl/run_sequencer.sv
// Host-side sequencer: streams operands into data memory, kicks the core,
// waits for done (or timeout), then streams the result block back out.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int AW         = 8,
  parameter int LOAD_BASE  = 0,
  parameter int LOAD_LEN   = 64,
  parameter int RES_BASE   = 64,
  parameter int RES_LEN    = 64,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  err,
  run_sequencer_if.slave        host,
  output logic                  mem_own,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_addr,
  output logic [7:0]            mem_wr_dat,
  input  logic [7:0]            mem_rd_dat,
  output logic                  core_req,
  input  logic                  core_done,
  output cyc_t                  run_cycles
);

  localparam logic [AW-1:0] LB = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RB = AW'(RES_BASE);
  localparam logic [AW-1:0] LL = AW'(LOAD_LEN - 1);
  localparam logic [AW-1:0] RL = AW'(RES_LEN - 1);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic          err_nx;
  logic          tmr_clr, tmr_en, tmr_last;

  run_timer #(.LIMIT(MAX_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .cnt   (run_cycles),
    .last  (tmr_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      err   <= err_nx;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    err_nx         = err;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    host.out_data  = '0;
    core_req       = 1'b0;
    mem_own        = 1'b1;
    mem_wr_en      = 1'b0;
    mem_addr       = LB + idx;
    mem_wr_dat     = host.in_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          idx_nx   = '0;
          err_nx   = 1'b0;
          tmr_clr  = 1'b1;
        end
      end
      LOAD: begin
        host.in_ready = 1'b1;
        mem_wr_en     = host.in_valid;
        if (host.in_valid) begin
          if (idx == LL) begin
            idx_nx   = '0;
            state_nx = KICK;
          end else begin
            idx_nx = idx + AW'(1);
          end
        end
      end
      KICK: begin
        // done is deliberately not looked at here: it may be stale
        core_req = 1'b1;
        mem_own  = 1'b0;
        state_nx = RUN;
      end
      RUN: begin
        mem_own = 1'b0;
        tmr_en  = 1'b1;
        if (core_done) begin
          state_nx = DRAIN;
        end else if (tmr_last) begin
          err_nx   = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        mem_addr       = RB + idx;
        host.out_valid = 1'b1;
        host.out_data  = mem_rd_dat;
        if (host.out_ready) begin
          if (idx == RL) begin
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + AW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: bench-side memory and core model,
// expected results derived from the load/run/drain rules per sequence.
module tb_run_sequencer;
  import run_sequencer_pkg::*;

  localparam int AW   = 8;
  localparam int LEN  = 4;
  localparam int RB   = 64;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, err, mem_own, mem_wr_en, core_req;
  logic          core_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_dat, mem_rd_dat;
  cyc_t          run_cycles;

  run_sequencer_if host ();

  run_sequencer #(
    .AW(AW), .LOAD_BASE(0), .LOAD_LEN(LEN),
    .RES_BASE(RB), .RES_LEN(LEN), .MAX_CYCLES(MAXC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .err        (err),
    .host       (host),
    .mem_own    (mem_own),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_dat (mem_wr_dat),
    .mem_rd_dat (mem_rd_dat),
    .core_req   (core_req),
    .core_done  (core_done),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  // Data memory; the backdoor port stands in for the core writing results.
  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_a = '0, bd_d = '0;

  always @(posedge clk) begin
    if (bd_we)                      mem[bd_a] <= bd_d;
    else if (mem_own && mem_wr_en)  mem[mem_addr] <= mem_wr_dat;
  end

  assign mem_rd_dat = mem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, {busy, err, host.in_ready, host.out_valid, core_req, mem_wr_en, mem_own},
        7'b0000001);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_cyc"}, run_cycles, 0);
    chk({tag, "_odat"}, host.out_data, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk_rst(tag);
    start          = 1'b0;
    host.in_valid  = 1'b0;
    host.out_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  // d: cycle after req at which done rises (0 = done already high from before)
  // gap: 0 continuous valid, 1 alternating, 2 random; abort: 1 mid-load, 2 mid-drain
  task automatic do_seq(input int d, input int gap, input int stall0, input int abort);
    logic [7:0] ib [LEN];
    logic [7:0] rs [LEN];
    int i, c, e, k;
    bit exp_err;
    for (int j = 0; j < LEN; j++) begin
      ib[j] = 8'($urandom);
      rs[j] = 8'($urandom);
      bd_we = 1'b1;
      bd_a  = 8'(RB + j);
      bd_d  = rs[j];
      tick();
    end
    bd_we = 1'b0;
    if (d == 0) core_done = 1'b1;
    e       = (d == 0) ? 1 : ((d < MAXC) ? d : MAXC);
    exp_err = (d > MAXC);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start", {busy, err, run_cycles}, {1'b1, 1'b0, 16'd0});

    i = 0;
    c = 0;
    while (i < LEN && c < 50) begin
      host.in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? 1'((c % 2) == 0) : 1'($urandom_range(0, 1));
      host.in_data  = ib[i];
      #1;
      chk("load_ctl", {host.in_ready, mem_own, mem_wr_en, core_req},
          {1'b1, 1'b1, host.in_valid, 1'b0});
      if (host.in_valid) chk("load_addr", mem_addr, i);
      if (abort == 1 && i == 2) begin
        do_reset("rst_load");
        return;
      end
      tick();
      if (host.in_valid) i++;
      c++;
    end
    if (i < LEN) chk("load_budget", i, LEN);
    host.in_valid = 1'b0;

    chk("kick", {core_req, mem_own, host.in_ready}, 3'b100);
    for (int j = 0; j < LEN; j++) chk("mem_load", mem[j], ib[j]);
    if (d != 0) core_done = 1'b0;
    tick();

    c = 0;
    while (!host.out_valid && c < 100) begin
      c++;
      start         = 1'($urandom_range(0, 1));
      host.in_valid = 1'($urandom_range(0, 1));
      chk("run_ctl", {core_req, mem_own, host.in_ready, mem_wr_en, busy}, 5'b00001);
      if (d != 0 && c >= d) core_done = 1'b1;
      tick();
    end
    start         = 1'b0;
    host.in_valid = 1'b0;
    chk("run_len", c, e);
    chk("run_cycles", run_cycles, e);
    chk("run_err", err, exp_err);

    for (int j = 0; j < LEN; j++) begin
      k = (j == 0) ? stall0 : $urandom_range(0, 2);
      host.out_ready = 1'b0;
      repeat (k) begin
        chk("drain_stall", {host.out_valid, host.out_data}, {1'b1, rs[j]});
        tick();
      end
      host.out_ready = 1'b1;
      #1;
      chk("drain", {host.out_valid, mem_own, host.out_data, mem_addr},
          {1'b1, 1'b1, rs[j], 8'(RB + j)});
      if (abort == 2 && j == 2) begin
        host.out_ready = 1'b0;
        do_reset("rst_drain");
        return;
      end
      tick();
    end
    host.out_ready = 1'b0;
    chk("end", {busy, host.out_valid, err, run_cycles}, {1'b0, 1'b0, exp_err, 16'(e)});
  endtask

  initial begin
    host.in_valid  = 1'b0;
    host.in_data   = '0;
    host.out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk_rst("reset");
    @(posedge clk);
    #3 reset = 1'b1;
    tick();

    do_seq(10,   0, 3, 0);
    do_seq(7,    1, 0, 0);
    do_seq(1000, 2, 1, 0);
    do_seq(5,    0, 0, 0);
    do_seq(20,   0, 0, 0);
    do_seq(21,   2, 0, 0);
    do_seq(0,    0, 2, 0);
    do_seq(9,    0, 0, 1);
    do_seq(3,    2, 0, 0);
    do_seq(12,   0, 1, 2);
    do_seq(4,    0, 0, 0);
    repeat (6) do_seq($urandom_range(1, 25), 2, $urandom_range(0, 3), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
